excp_commit_ctrl: RTL
=====================

// Module: excp_commit_ctrl
// PURPOSE
//  Commit-point sequencer for exceptions, interrupts and ertn at the writeback boundary.
//  - Captures the trapping WB-stage instruction.
//  - Waits until the icache is idle, then fires one single-cycle flush with registered cause/badv/era.
//  - Holds the pipeline for a programmable drain window before returning to idle.
//  - Sits between the MEM->WB bus and the CSR unit; replaces the combinational flush/cause path.
// PARAMETERS
//  DRAIN_CYCLES  2   post-flush cycles with stall held high (0 = no drain)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-low reset
//  icache_busy  in   1   icache refill in progress; flush must not fire while high
//  left_valid   in   1   WB-stage instruction valid
//  ms_excp      in   1   instruction carries an exception
//  ertn         in   1   instruction is ertn
//  excp_num     in   16  one-hot-ish cause vector: [0]int [1]adef [2]tlbr [3]pif [4]ppi [5]sys
//                        [6]brk [7]ine [8]ipe [9]ale [10]adem [11]tlbr [12]pme [13]ppi [14]pis [15]pil
//  int_pending  in   1   CSR interrupt request (enabled & pending)
//  pc           in   32  WB instruction PC
//  mem_addr     in   32  WB memory address
//  stall        out  1   hold WB (left_ready low, right_valid low) and block its writeback
//  excp_flush   out  1   one-cycle exception/interrupt flush pulse
//  ertn_flush   out  1   one-cycle ertn flush pulse
//  excp_era     out  32  captured pc
//  ecode        out  6   cause code
//  esubcode     out  9   cause sub-code
//  badv         out  32  bad virtual address
//  badv_valid   out  1   badv must be written
//  busy         out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset and states
//  - Reset (reset==0 at posedge): FSM->IDLE, drain counter 0, all outputs and capture regs 0.
//    Applies mid-sequence too; a pending flush is dropped.
//  - States: IDLE, WAIT_IC, COMMIT, DRAIN.
//  Trigger and capture
//  - trig = left_valid & (ms_excp | ertn | int_pending).
//  - IDLE & trig: capture pc, mem_addr, excp_num, ertn, and int = int_pending.
//    Next state is WAIT_IC if icache_busy, else COMMIT.
//  - In IDLE, stall = trig (combinational), so the trapping instruction never retires.
//  State transitions
//  - WAIT_IC: stall=1; stays until icache_busy==0, then COMMIT. Inputs are ignored.
//  - COMMIT: stall=1 and exactly one flush pulse.
//    - excp_flush=1 if captured ms_excp|int.
//    - Otherwise ertn_flush=1.
//    - Never both; exception beats ertn.
//    - Next state is DRAIN with counter=DRAIN_CYCLES-1, or IDLE if DRAIN_CYCLES==0.
//  - DRAIN: stall=1, flushes 0; counter decrements each cycle; ->IDLE on the cycle counter==0.
//  - busy = (state!=IDLE). Latency trig->flush = 1 cycle + icache-wait cycles.
//  Cause encoding (registered on COMMIT entry; held until the next capture)
//  - Priority: int_pending|excp_num[0] first, then excp_num[1..15] low index first.
//  - [0]: ECODE_INT, badv_valid 0.
//  - [1]: ECODE_ADEF, ESUBCODE_ADEF, badv=pc.
//  - [2..4]: TLBR/PIF/PPI, badv=pc.
//  - [5..8]: SYS/BRK/INE/IPE, badv 0, badv_valid 0.
//  - [9]: ALE, badv=mem_addr.
//  - [10]: ADEM, ESUBCODE_ADEM, badv=mem_addr.
//  - [11..15]: TLBR/PME/PPI/PIS/PIL, badv=mem_addr.
//  - Every non-listed esubcode is 0. badv_valid=1 exactly for bits 1-4 and 9-15.
//  - ms_excp with excp_num==0: ecode 0, badv_valid 0; flush still fires.
//  - ertn only: ecode/esubcode/badv/badv_valid 0; excp_era=pc.
//  Boundaries
//  - A trig arriving while not IDLE is not captured; stall keeps it in WB until IDLE.
//  - icache_busy toggling in COMMIT/DRAIN has no effect.
//  - Counter width $clog2(DRAIN_CYCLES+1), minimum 1.
// TESTING
//  1. ms_excp=1, excp_num=16'h0200, mem_addr=32'h1003, icache_busy=0
//     -> excp_flush for exactly 1 cycle, next cycle; ecode=ECODE_ALE, badv=32'h1003, badv_valid=1;
//     stall high 1+2 cycles after trig.
//  2. excp_num=16'h0002, pc=32'h1c000004, icache_busy held high 5 cycles
//     -> no flush during busy; single excp_flush the cycle after busy drops;
//     ecode=ECODE_ADEF, esubcode=ESUBCODE_ADEF, badv=pc.
//  3. ertn=1, ms_excp=0 -> ertn_flush pulse, excp_flush=0, excp_era=pc, ecode=0.
//     ertn=1 & ms_excp=1 -> excp_flush only.
//  4. int_pending=1 with excp_num=16'h0040 (brk) -> ecode=ECODE_INT, badv_valid=0.
//  5. New trig during DRAIN -> not captured, stall stays high;
//     captured in IDLE and flushed once more (two flushes total).
//  6. reset=0 while in WAIT_IC -> next cycle state IDLE, busy=0, all outputs 0, no flush afterwards.

Source files
------------

// File: rtl/excp_commit_ctrl_if.sv
// WB-boundary bus between the writeback stage, the icache status and the CSR unit.
// The master drives the WB-stage instruction; the slave (commit controller) answers with
// stall/flush and the registered trap cause.
interface excp_commit_ctrl_if;
    // WB-stage / icache side
    logic        icache_busy;
    logic        left_valid;
    logic        ms_excp;
    logic        ertn;
    logic [15:0] excp_num;
    logic        int_pending;
    logic [31:0] pc;
    logic [31:0] mem_addr;
    // Commit / CSR side
    logic        stall;
    logic        excp_flush;
    logic        ertn_flush;
    logic [31:0] excp_era;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] badv;
    logic        badv_valid;
    logic        busy;

    modport master (
        output icache_busy, left_valid, ms_excp, ertn, excp_num, int_pending, pc, mem_addr,
        input  stall, excp_flush, ertn_flush, excp_era, ecode, esubcode, badv, badv_valid, busy
    );

    modport slave (
        input  icache_busy, left_valid, ms_excp, ertn, excp_num, int_pending, pc, mem_addr,
        output stall, excp_flush, ertn_flush, excp_era, ecode, esubcode, badv, badv_valid, busy
    );
endinterface

// File: rtl/excp_commit_ctrl.sv
// Commit-point sequencer for exceptions, interrupts and ertn. Captures the trapping WB
// instruction, waits for the icache to go idle, fires a single flush pulse with registered
// cause/badv/era, then holds the pipeline for a drain window.
module excp_commit_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input logic               clk,
    input logic               reset,
    excp_commit_ctrl_if.slave bus
);

    localparam int unsigned CntW = (DRAIN_CYCLES == 0) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CntW-1:0] DrainInit =
        CntW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

    // Exception codes
    localparam logic [5:0] EcodeInt  = 6'h00;
    localparam logic [5:0] EcodePil  = 6'h01;
    localparam logic [5:0] EcodePis  = 6'h02;
    localparam logic [5:0] EcodePif  = 6'h03;
    localparam logic [5:0] EcodePme  = 6'h04;
    localparam logic [5:0] EcodePpi  = 6'h07;
    localparam logic [5:0] EcodeAde  = 6'h08;
    localparam logic [5:0] EcodeAle  = 6'h09;
    localparam logic [5:0] EcodeSys  = 6'h0b;
    localparam logic [5:0] EcodeBrk  = 6'h0c;
    localparam logic [5:0] EcodeIne  = 6'h0d;
    localparam logic [5:0] EcodeIpe  = 6'h0e;
    localparam logic [5:0] EcodeTlbr = 6'h3f;

    localparam logic [8:0] EsubcodeAdef = 9'h000;
    localparam logic [8:0] EsubcodeAdem = 9'h001;

    typedef enum logic [1:0] {
        StIdle,
        StWaitIc,
        StCommit,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;

    logic            trig;
    logic            is_excp_in;

    // Capture registers; these drive the CSR-facing outputs directly
    logic            is_excp_q;
    logic [31:0]     era_q;
    logic [5:0]      ecode_q;
    logic [8:0]      esubcode_q;
    logic [31:0]     badv_q;
    logic            badv_valid_q;

    // Cause decode from the live WB inputs, only latched on capture
    logic [5:0]      cause_ecode;
    logic [8:0]      cause_esubcode;
    logic [31:0]     cause_badv;
    logic            cause_badv_valid;
    logic [3:0]      first_idx;
    logic            found;

    assign trig       = bus.left_valid & (bus.ms_excp | bus.ertn | bus.int_pending);
    assign is_excp_in = bus.ms_excp | bus.int_pending;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    state_d = bus.icache_busy ? StWaitIc : StCommit;
                end
            end
            StWaitIc: begin
                if (!bus.icache_busy) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = (DRAIN_CYCLES == 0) ? StIdle : StDrain;
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: stall/flush/busy decoded from the state
    always_comb begin
        bus.stall      = 1'b0;
        bus.excp_flush = 1'b0;
        bus.ertn_flush = 1'b0;
        bus.busy       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Hold the trapping instruction in WB in its very first cycle
                bus.stall = trig;
            end
            StWaitIc: begin
                bus.stall = 1'b1;
                bus.busy  = 1'b1;
            end
            StCommit: begin
                bus.stall      = 1'b1;
                bus.busy       = 1'b1;
                bus.excp_flush = is_excp_q;
                bus.ertn_flush = ~is_excp_q;
            end
            StDrain: begin
                bus.stall = 1'b1;
                bus.busy  = 1'b1;
            end
            default: begin
                bus.stall = 1'b0;
            end
        endcase
    end

    // Drain-window counter, loaded while in COMMIT
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == StCommit) begin
            cnt_q <= DrainInit;
        end else if (state_q == StDrain && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Cause decode: interrupt first, then lowest set excp_num bit
    always_comb begin
        cause_ecode      = '0;
        cause_esubcode   = '0;
        cause_badv       = '0;
        cause_badv_valid = 1'b0;
        first_idx        = 4'd0;
        found            = 1'b0;
        for (int i = 15; i >= 1; i--) begin
            if (bus.excp_num[i]) begin
                first_idx = 4'(i);
                found     = 1'b1;
            end
        end
        if (!is_excp_in) begin
            // ertn only: cause fields stay zero
            cause_ecode = '0;
        end else if (bus.int_pending || bus.excp_num[0]) begin
            cause_ecode = EcodeInt;
        end else if (found) begin
            unique case (first_idx)
                4'd1: begin
                    cause_ecode      = EcodeAde;
                    cause_esubcode   = EsubcodeAdef;
                    cause_badv       = bus.pc;
                    cause_badv_valid = 1'b1;
                end
                4'd2: begin
                    cause_ecode      = EcodeTlbr;
                    cause_badv       = bus.pc;
                    cause_badv_valid = 1'b1;
                end
                4'd3: begin
                    cause_ecode      = EcodePif;
                    cause_badv       = bus.pc;
                    cause_badv_valid = 1'b1;
                end
                4'd4: begin
                    cause_ecode      = EcodePpi;
                    cause_badv       = bus.pc;
                    cause_badv_valid = 1'b1;
                end
                4'd5: cause_ecode = EcodeSys;
                4'd6: cause_ecode = EcodeBrk;
                4'd7: cause_ecode = EcodeIne;
                4'd8: cause_ecode = EcodeIpe;
                4'd9: begin
                    cause_ecode      = EcodeAle;
                    cause_badv       = bus.mem_addr;
                    cause_badv_valid = 1'b1;
                end
                4'd10: begin
                    cause_ecode      = EcodeAde;
                    cause_esubcode   = EsubcodeAdem;
                    cause_badv       = bus.mem_addr;
                    cause_badv_valid = 1'b1;
                end
                4'd11: begin
                    cause_ecode      = EcodeTlbr;
                    cause_badv       = bus.mem_addr;
                    cause_badv_valid = 1'b1;
                end
                4'd12: begin
                    cause_ecode      = EcodePme;
                    cause_badv       = bus.mem_addr;
                    cause_badv_valid = 1'b1;
                end
                4'd13: begin
                    cause_ecode      = EcodePpi;
                    cause_badv       = bus.mem_addr;
                    cause_badv_valid = 1'b1;
                end
                4'd14: begin
                    cause_ecode      = EcodePis;
                    cause_badv       = bus.mem_addr;
                    cause_badv_valid = 1'b1;
                end
                4'd15: begin
                    cause_ecode      = EcodePil;
                    cause_badv       = bus.mem_addr;
                    cause_badv_valid = 1'b1;
                end
                default: cause_ecode = '0;
            endcase
        end
    end

    // Capture the trapping instruction; values are held until the next capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            is_excp_q    <= 1'b0;
            era_q        <= '0;
            ecode_q      <= '0;
            esubcode_q   <= '0;
            badv_q       <= '0;
            badv_valid_q <= 1'b0;
        end else if (state_q == StIdle && trig) begin
            is_excp_q    <= is_excp_in;
            era_q        <= bus.pc;
            ecode_q      <= cause_ecode;
            esubcode_q   <= cause_esubcode;
            badv_q       <= cause_badv;
            badv_valid_q <= cause_badv_valid;
        end
    end

    assign bus.excp_era   = era_q;
    assign bus.ecode      = ecode_q;
    assign bus.esubcode   = esubcode_q;
    assign bus.badv       = badv_q;
    assign bus.badv_valid = badv_valid_q;

endmodule
